display_refresh_ctrl: RTL and testbench
=======================================

Name: display_refresh_ctrl

Overview:
Sequencer for the BCD→7-segment decode/shift engine that drives the digit shift-register chain. It picks the value to display (live counter or held snapshot) and triggers the engine periodically or on demand. It counts the engine's shift-clock pulses to detect completion, then pulses the storage-register latch. A watchdog flags an engine that never finishes. The block sits between the counter core and the decode/shift engine in the top level.

Parameters:
DIGITS, 6, number of BCD digits / parallel segment lines
REFRESH_DIV, 1000, clk cycles between automatic refreshes (≥ 2)
BITS_PER_DIGIT, 8, shift-clock rising edges per complete engine transfer
TIMEOUT, 64, max cycles allowed in RUN before abort

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
en  in  1  allows new transactions; an in-flight transaction always completes
live_in  in  4*DIGITS  live BCD counter value
hold_in  in  4*DIGITS  held/captured BCD value
hold_sel  in  1  1 = display hold_in, 0 = display live_in
upd_req  in  1  one-cycle request for an immediate refresh
eng_shift  in  1  engine shift-clock output
eng_cnt  out  4*DIGITS  value presented to the engine
eng_trigger  out  1  one-cycle start pulse to the engine
latch  out  1  one-cycle storage-register strobe
oe_n  out  1  display output enable, active-low
busy  out  1  high whenever state ≠ IDLE
err  out  1  sticky watchdog-timeout flag

Behaviour:
- All outputs are registered.
- Reset values: eng_cnt=0, eng_trigger=0, latch=0, oe_n=1, busy=0, err=0; state=IDLE; refresh timer=REFRESH_DIV-1; pending=0; edge counter and watchdog = 0.
- Refresh timer:
  - When en=1, decrements every cycle in every state.
  - At 0 it sets pending and reloads REFRESH_DIV-1.
  - When en=0, it is held at REFRESH_DIV-1.
- upd_req=1 sets pending in any state, regardless of en.
- Multiple requests while busy coalesce into one pending bit.
- States: IDLE → ARM → RUN → SETTLE → LATCH → IDLE. RUN can also go → IDLE on timeout.
- IDLE:
  - If pending and en: capture eng_cnt ← (hold_sel ? hold_in : live_in), clear pending, go to ARM.
  - A request arriving in the same cycle pending is cleared re-sets it (set wins).
- ARM (1 cycle):
  - eng_trigger=1, edge counter=0, watchdog=0, then go to RUN.
  - Trigger therefore rises 1 cycle after the IDLE decision.
- RUN:
  - eng_shift is registered into shift_q; a rising edge is eng_shift & ~shift_q.
  - Each rising edge increments the edge counter.
  - When the counter reaches BITS_PER_DIGIT and eng_shift=0, go to SETTLE.
  - The watchdog increments each RUN cycle. On reaching TIMEOUT-1 without completing: err←1, go to IDLE, no latch pulse.
- SETTLE: 1 cycle, then LATCH.
- LATCH: latch=1 for exactly this cycle, then IDLE.
- eng_cnt is stable from capture until the next capture; it never changes while busy=1.
- hold_sel and live_in changes during busy have no effect on the current transfer.
- err clears only on reset.
- oe_n stays 1 until the first latch pulse after reset; afterwards it follows the optional feature.
- Extra rising edges beyond BITS_PER_DIGIT in RUN are ignored; the counter saturates.
- Reset mid-transaction: immediate return to reset values; no latch, no trigger.

Optional Feature:
- Macro: OE_PWM_EN.
- Enabled:
  - Adds input brightness[3:0] and a free-running 4-bit PWM counter (reset 0).
  - After the first latch, oe_n = (pwm_cnt >= brightness).
  - brightness=0 → display off; brightness=15 → on 15/16 of cycles.
- Disabled:
  - No brightness port.
  - oe_n = 0 permanently after the first latch.

Decomposition:
- Shared package: state encoding constants (IDLE, ARM, RUN, SETTLE, LATCH) and default parameter constants.
- Width constants derived with $clog2: refresh timer, edge counter, watchdog.
- One natural sub-module: refresh_timer (down-counter with en, reload, expiry pulse).
- The FSM, source mux and optional PWM stay in the top module.

Test Plan:
- Periodic refresh, with DIGITS=6, REFRESH_DIV=100, en=1, live_in=24'h123456, and an engine model emitting 8 shift pulses after trigger:
  - eng_trigger every 100 cycles;
  - eng_cnt=24'h123456 at each trigger;
  - one latch per transfer;
  - err=0.
- Source select: hold_sel=1, hold_in=24'h000042 → eng_cnt=24'h000042. Toggling hold_sel mid-RUN leaves eng_cnt unchanged until the next capture.
- Request coalescing, with en=1: three upd_req pulses during RUN → exactly one additional trigger after LATCH; 2 triggers and 2 latches total.
- Watchdog: engine model emits only 5 pulses, TIMEOUT=64 → state returns to IDLE 64 cycles after entering RUN; err=1 and stays 1; no latch pulse.
- Reset mid-RUN (after 3 shift edges): all outputs at reset values on the next edge; no latch; the next transaction proceeds normally after en.
- With OE_PWM_EN and brightness=4, after the first latch: oe_n low for exactly 4 of every 16 cycles. With brightness=0: oe_n constantly 1.

Source files
------------

// File: rtl/display_refresh_ctrl_pkg.sv
// rtl/display_refresh_ctrl_pkg.sv - shared state encoding and default parameters for the display refresh sequencer
package display_refresh_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        LATCH  = 3'd4
    } state_t;

    localparam int DEF_DIGITS         = 6;
    localparam int DEF_REFRESH_DIV    = 1000;
    localparam int DEF_BITS_PER_DIGIT = 8;
    localparam int DEF_TIMEOUT        = 64;

endpackage

// File: rtl/display_refresh_ctrl_refresh_timer.sv
// rtl/display_refresh_ctrl_refresh_timer.sv - periodic refresh down-counter with reload and expiry pulse
module display_refresh_ctrl_refresh_timer #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic expire
);

    localparam int             W      = $clog2(DIV);
    localparam logic [W-1:0]   RELOAD = W'(DIV - 1);

    logic [W-1:0] cnt;

    // Held at the reload value while disabled so a re-enable always starts a full period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= RELOAD;
        end else if (!en || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = en && (cnt == '0);

endmodule

// File: rtl/display_refresh_ctrl.sv
// rtl/display_refresh_ctrl.sv - refresh sequencer for the 7-segment shift engine; optional PWM dimming under OE_PWM_EN
module display_refresh_ctrl
    import display_refresh_ctrl_pkg::*;
#(
    parameter int DIGITS         = DEF_DIGITS,
    parameter int REFRESH_DIV    = DEF_REFRESH_DIV,
    parameter int BITS_PER_DIGIT = DEF_BITS_PER_DIGIT,
    parameter int TIMEOUT        = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   live_in,
    input  logic [4*DIGITS-1:0]   hold_in,
    input  logic                  hold_sel,
    input  logic                  upd_req,
    input  logic                  eng_shift,
`ifdef OE_PWM_EN
    input  logic [3:0]            brightness,
`endif
    output logic [4*DIGITS-1:0]   eng_cnt,
    output logic                  eng_trigger,
    output logic                  latch,
    output logic                  oe_n,
    output logic                  busy,
    output logic                  err
);

    localparam int            EW        = $clog2(BITS_PER_DIGIT + 1);
    localparam int            WW        = $clog2(TIMEOUT);
    localparam logic [EW-1:0] EDGE_DONE = EW'(BITS_PER_DIGIT);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);

    state_t          state, next_state;
    logic            tick;
    logic            pending;
    logic            shift_q;
    logic [EW-1:0]   edge_cnt;
    logic [WW-1:0]   wd_cnt;
    logic            seen_latch;
    logic            capture;
    logic            rise;
    logic            done;

    display_refresh_ctrl_refresh_timer #(.DIV(REFRESH_DIV)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .expire (tick)
    );

    assign capture = (state == IDLE) && pending && en;
    assign rise    = eng_shift && !shift_q;
    assign done    = (edge_cnt == EDGE_DONE) && !eng_shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pending && en) next_state = ARM;
            ARM:     next_state = RUN;
            RUN: begin
                if (done) begin
                    next_state = SETTLE;
                end else if (wd_cnt == WD_LAST) begin
                    next_state = IDLE;
                end
            end
            SETTLE:  next_state = LATCH;
            LATCH:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

`ifdef OE_PWM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending     <= 1'b0;
            shift_q     <= 1'b0;
            edge_cnt    <= '0;
            wd_cnt      <= '0;
            seen_latch  <= 1'b0;
            eng_cnt     <= '0;
            eng_trigger <= 1'b0;
            latch       <= 1'b0;
            oe_n        <= 1'b1;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            shift_q <= eng_shift;
            // A new request in the capture cycle survives the clear.
            pending <= upd_req || tick || (pending && !capture);

            if (capture) begin
                eng_cnt <= hold_sel ? hold_in : live_in;
            end

            if (state == ARM) begin
                edge_cnt <= '0;
                wd_cnt   <= '0;
            end else if (state == RUN) begin
                if (rise && edge_cnt != EDGE_DONE) begin
                    edge_cnt <= edge_cnt + 1'b1;
                end
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (state == RUN && next_state == IDLE) begin
                err <= 1'b1;
            end
            if (state == LATCH) begin
                seen_latch <= 1'b1;
            end

            eng_trigger <= (next_state == ARM);
            latch       <= (next_state == LATCH);
            busy        <= (next_state != IDLE);

`ifdef OE_PWM_EN
            oe_n <= (seen_latch || state == LATCH) ? (pwm_cnt >= brightness) : 1'b1;
`else
            oe_n <= !(seen_latch || state == LATCH);
`endif
        end
    end

endmodule

// File: tb/tb_display_refresh_ctrl.sv
// tb/tb_display_refresh_ctrl.sv - directed self-checking bench for display_refresh_ctrl
module tb_display_refresh_ctrl;

    localparam int DIGITS = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [23:0]       live_in;
    logic [23:0]       hold_in;
    logic              hold_sel;
    logic              upd_req;
    logic              eng_shift = 1'b0;
`ifdef OE_PWM_EN
    logic [3:0]        brightness = 4'd0;
`endif
    logic [23:0]       eng_cnt;
    logic              eng_trigger;
    logic              latch;
    logic              oe_n;
    logic              busy;
    logic              err;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int trig_cnt  = 0;
    int latch_cnt = 0;
    int eng_pulses = 8;
    int eng_rem   = 0;

    typedef struct {
        logic        hs;
        logic [23:0] live;
        logic [23:0] hold;
        logic [23:0] exp_cnt;
    } vec_t;

    display_refresh_ctrl #(
        .DIGITS         (DIGITS),
        .REFRESH_DIV    (100),
        .BITS_PER_DIGIT (8),
        .TIMEOUT        (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .live_in     (live_in),
        .hold_in     (hold_in),
        .hold_sel    (hold_sel),
        .upd_req     (upd_req),
        .eng_shift   (eng_shift),
`ifdef OE_PWM_EN
        .brightness  (brightness),
`endif
        .eng_cnt     (eng_cnt),
        .eng_trigger (eng_trigger),
        .latch       (latch),
        .oe_n        (oe_n),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: after a trigger emits eng_pulses high/low shift pulses, one half per cycle.
    always @(negedge clk) begin
        if (reset) begin
            eng_rem   = 0;
            eng_shift = 1'b0;
        end else if (eng_trigger) begin
            trig_cnt++;
            eng_rem   = eng_pulses * 2;
            eng_shift = 1'b0;
        end else if (eng_rem > 0) begin
            eng_shift = (eng_rem % 2 == 0);
            eng_rem--;
        end
        if (latch) latch_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_trig(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (eng_trigger === 1'b1);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s actual=no_trigger expected=trigger_within_%0d", name, budget);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit seen = (busy === 1'b0);
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (busy === 1'b0);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s actual=busy expected=idle_within_%0d", name, budget);
        end
    endtask

    task automatic pulse_req();
        upd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
    endtask

    task automatic restart_timer();
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
    endtask

    initial begin
        vec_t vecs [4];
        int   t0;
        int   l0;
        int   n;

        vecs[0] = '{hs: 1'b0, live: 24'h123456, hold: 24'h000042, exp_cnt: 24'h123456};
        vecs[1] = '{hs: 1'b1, live: 24'h123456, hold: 24'h000042, exp_cnt: 24'h000042};
        vecs[2] = '{hs: 1'b1, live: 24'h000000, hold: 24'h999999, exp_cnt: 24'h999999};
        vecs[3] = '{hs: 1'b0, live: 24'h987654, hold: 24'h000001, exp_cnt: 24'h987654};

        reset = 1'b1; en = 1'b0; hold_sel = 1'b0; upd_req = 1'b0;
        live_in = '0; hold_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_eng_cnt", eng_cnt, 0);
        chk("rst_trigger", eng_trigger, 0);
        chk("rst_latch", latch, 0);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);

        reset = 1'b0;
        @(negedge clk);

        // Periodic refresh
        live_in = 24'h123456;
        en = 1'b1;
        wait_trig("periodic_trig1", 150);
        t0 = cyc; l0 = latch_cnt;
        chk("periodic_cnt1", eng_cnt, 24'h123456);
        wait_trig("periodic_trig2", 150);
        chk("periodic_interval1", cyc - t0, 100);
        chk("periodic_cnt2", eng_cnt, 24'h123456);
        chk("periodic_latches", latch_cnt - l0, 1);
        t0 = cyc;
        wait_trig("periodic_trig3", 150);
        chk("periodic_interval2", cyc - t0, 100);
        chk("periodic_err", err, 0);
`ifndef OE_PWM_EN
        chk("periodic_oe_n", oe_n, 0);
`endif

        // Source select table
        for (int i = 0; i < 4; i++) begin
            wait_idle("tbl_idle", 200);
            hold_sel = vecs[i].hs;
            live_in  = vecs[i].live;
            hold_in  = vecs[i].hold;
            pulse_req();
            wait_trig("tbl_trig", 150);
            chk($sformatf("tbl_cnt_%0d", i), eng_cnt, vecs[i].exp_cnt);
        end

        // hold_sel toggled mid-RUN
        wait_idle("hold_idle", 200);
        hold_sel = 1'b1; hold_in = 24'h000042; live_in = 24'h111111;
        pulse_req();
        wait_trig("hold_trig", 150);
        repeat (4) @(negedge clk);
        hold_sel = 1'b0; live_in = 24'h999999; hold_in = 24'h000000;
        @(negedge clk);
        chk("hold_busy_mid", busy, 1);
        chk("hold_cnt_mid", eng_cnt, 24'h000042);
        wait_idle("hold_idle2", 200);
        chk("hold_cnt_end", eng_cnt, 24'h000042);

        // Request coalescing
        restart_timer();
        t0 = trig_cnt; l0 = latch_cnt;
        live_in = 24'h000777;
        pulse_req();
        wait_trig("coal_trig", 150);
        repeat (3) @(negedge clk);
        pulse_req(); @(negedge clk);
        pulse_req(); @(negedge clk);
        pulse_req();
        repeat (60) @(negedge clk);
        chk("coal_triggers", trig_cnt - t0, 2);
        chk("coal_latches", latch_cnt - l0, 2);
        chk("coal_busy", busy, 0);

        // Watchdog timeout
        wait_idle("wd_idle", 200);
        restart_timer();
        eng_pulses = 5;
        l0 = latch_cnt;
        pulse_req();
        wait_trig("wd_trig", 150);
        repeat (64) @(negedge clk);
        chk("wd_busy_last_run", busy, 1);
        chk("wd_err_before", err, 0);
        @(negedge clk);
        chk("wd_busy_after", busy, 0);
        chk("wd_err_set", err, 1);
        chk("wd_no_latch", latch_cnt - l0, 0);
        eng_pulses = 8;
        pulse_req();
        wait_trig("wd_trig2", 150);
        wait_idle("wd_idle2", 200);
        chk("wd_err_sticky", err, 1);
        chk("wd_next_latch", latch_cnt - l0, 1);

        // Reset mid-RUN after three shift edges
        wait_idle("rr_idle", 200);
        l0 = latch_cnt;
        pulse_req();
        wait_trig("rr_trig", 150);
        repeat (6) @(negedge clk);
        chk("rr_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        chk("rr_eng_cnt", eng_cnt, 0);
        chk("rr_busy", busy, 0);
        chk("rr_err", err, 0);
        chk("rr_oe_n", oe_n, 1);
        chk("rr_trigger", eng_trigger, 0);
        chk("rr_latch", latch, 0);
        repeat (3) @(negedge clk);
        chk("rr_no_latch", latch_cnt - l0, 0);
        reset = 1'b0;
        @(negedge clk);
        live_in = 24'h314159; hold_sel = 1'b0;
        pulse_req();
        wait_trig("rr_trig2", 150);
        chk("rr_cnt2", eng_cnt, 24'h314159);
        wait_idle("rr_idle2", 200);
        chk("rr_latch2", latch_cnt - l0, 1);
        chk("rr_err2", err, 0);
`ifndef OE_PWM_EN
        chk("rr_oe_n2", oe_n, 0);
`endif

`ifdef OE_PWM_EN
        brightness = 4'd4;
        repeat (2) @(negedge clk);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (oe_n == 1'b0) n++;
        end
        chk("pwm_b4_low", n, 4);
        brightness = 4'd0;
        repeat (2) @(negedge clk);
        n = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (oe_n == 1'b0) n++;
        end
        chk("pwm_b0_low", n, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
